// File: rtl/axi_slave_pkg.sv
// Shared encodings for the AXI slave write controller: response codes,
// burst types, the only supported beat size, and the controller state type.
package axi_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [2:0] SIZE_WORD   = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } wr_state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Word address register and beat counter for one write burst. The address
// carries one extra MSB so that stepping past the last SRAM word is visible.
module axi_burst_addr_gen
  import axi_slave_pkg::*;
#(
  parameter int MADDR_W = 14,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               advance,
  input  logic [1:0]         burst,
  input  logic [MADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]   len,
  output logic [MADDR_W-1:0] addr,
  output logic               last_beat,
  output logic               overflow
);

  logic [MADDR_W:0]   addr_q, addr_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               incr_q, incr_d;

  always_comb begin
    // NOTE: every *_d gets a hold default first so no path leaves it unassigned (no latch).
    addr_d = addr_q;
    beat_d = beat_q;
    len_d  = len_q;
    incr_d = incr_q;
    if (load) begin
      addr_d = {1'b0, start_addr};
      beat_d = '0;
      len_d  = len;
      incr_d = (burst == BURST_INCR);
    end else if (advance) begin
      beat_d = beat_q + 1'b1;
      if (incr_q) addr_d = addr_q + 1'b1;
    end
  end

  // NOTE: flops use non-blocking <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      beat_q <= '0;
      len_q  <= '0;
      incr_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      beat_q <= beat_d;
      len_q  <= len_d;
      incr_q <= incr_d;
    end
  end

  assign addr      = addr_q[MADDR_W-1:0];
  assign overflow  = addr_q[MADDR_W];
  assign last_beat = (beat_q == len_q);

endmodule

// File: rtl/axi_slave_write_ctrl.sv
// AXI slave write responder: accepts one AW burst, turns each W beat into a
// byte-enabled SRAM word write, then returns a single B response.
module axi_slave_write_ctrl
  import axi_slave_pkg::*;
#(
  parameter int ID_W      = 8,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 4,
  parameter int MEM_WORDS = 16384,
  parameter int MADDR_W   = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ID_W-1:0]    AWID_S,
  input  logic [ADDR_W-1:0]  AWADDR_S,
  input  logic [LEN_W-1:0]   AWLEN_S,
  input  logic [2:0]         AWSIZE_S,
  input  logic [1:0]         AWBURST_S,
  input  logic               AWVALID_S,
  output logic               AWREADY_S,
  input  logic [DATA_W-1:0]  WDATA_S,
  input  logic [3:0]         WSTRB_S,
  input  logic               WLAST_S,
  input  logic               WVALID_S,
  output logic               WREADY_S,
  output logic [ID_W-1:0]    BID_S,
  output logic [1:0]         BRESP_S,
  output logic               BVALID_S,
  input  logic               BREADY_S,
  output logic               mem_we,
  output logic [MADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic [3:0]         mem_bweb
);

  wr_state_t         state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              err_q, err_d;             // suppresses SRAM writes
  logic              wlast_err_q, wlast_err_d; // protocol-only, writes continue

  logic               in_idle, in_data, in_resp;
  logic               aw_hs, w_hs, aw_err, beat_err;
  logic [MADDR_W-1:0] cur_addr;
  logic               last_beat, overflow;
  logic               unused_addr_lsbs;

  // Outputs decode registered state; rst gating makes writes stop in the reset cycle itself.
  assign in_idle = (state_q == IDLE) & ~rst;
  assign in_data = (state_q == DATA) & ~rst;
  assign in_resp = (state_q == RESP) & ~rst;

  assign aw_hs    = AWVALID_S & in_idle;
  assign w_hs     = WVALID_S & in_data;
  assign aw_err   = (AWSIZE_S != SIZE_WORD)
                  | (|AWADDR_S[ADDR_W-1:MADDR_W+2])
                  | ((AWBURST_S != BURST_FIXED) & (AWBURST_S != BURST_INCR));
  assign beat_err = err_q | overflow;

  assign unused_addr_lsbs = ^AWADDR_S[1:0];

  axi_burst_addr_gen #(
    .MADDR_W (MADDR_W),
    .LEN_W   (LEN_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (aw_hs),
    .advance    (w_hs),
    .burst      (AWBURST_S),
    .start_addr (AWADDR_S[MADDR_W+1:2]),
    .len        (AWLEN_S),
    .addr       (cur_addr),
    .last_beat  (last_beat),
    .overflow   (overflow)
  );

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    err_d       = err_q;
    wlast_err_d = wlast_err_q;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          id_d        = AWID_S;
          err_d       = aw_err;
          wlast_err_d = 1'b0;
          state_d     = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          if (overflow) err_d = 1'b1;
          if (WLAST_S != last_beat) wlast_err_d = 1'b1;
          if (last_beat) state_d = RESP;
        end
      end
      RESP: begin
        if (BREADY_S) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      id_q        <= '0;
      err_q       <= 1'b0;
      wlast_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      err_q       <= err_d;
      wlast_err_q <= wlast_err_d;
    end
  end

  assign AWREADY_S = in_idle;
  assign WREADY_S  = in_data;
  assign BVALID_S  = in_resp;
  assign BID_S     = in_resp ? id_q : '0;
  assign BRESP_S   = (in_resp & (err_q | wlast_err_q)) ? RESP_SLVERR : RESP_OKAY;

  assign mem_we    = w_hs & ~beat_err;
  assign mem_addr  = in_data ? cur_addr : '0;
  assign mem_wdata = in_data ? WDATA_S : '0;
  assign mem_bweb  = WSTRB_S & {4{in_data & ~beat_err}};

endmodule

// File: tb/tb_axi_slave_write_ctrl.sv
// Directed self-checking bench for axi_slave_write_ctrl: one task per scenario,
// inputs driven 1 ns after the rising edge, outputs sampled on the falling edge.
module tb_axi_slave_write_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  AWID_S;
  logic [31:0] AWADDR_S;
  logic [3:0]  AWLEN_S;
  logic [2:0]  AWSIZE_S;
  logic [1:0]  AWBURST_S;
  logic        AWVALID_S;
  logic        AWREADY_S;
  logic [31:0] WDATA_S;
  logic [3:0]  WSTRB_S;
  logic        WLAST_S;
  logic        WVALID_S;
  logic        WREADY_S;
  logic [7:0]  BID_S;
  logic [1:0]  BRESP_S;
  logic        BVALID_S;
  logic        BREADY_S;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_bweb;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  axi_slave_write_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .AWID_S    (AWID_S),
    .AWADDR_S  (AWADDR_S),
    .AWLEN_S   (AWLEN_S),
    .AWSIZE_S  (AWSIZE_S),
    .AWBURST_S (AWBURST_S),
    .AWVALID_S (AWVALID_S),
    .AWREADY_S (AWREADY_S),
    .WDATA_S   (WDATA_S),
    .WSTRB_S   (WSTRB_S),
    .WLAST_S   (WLAST_S),
    .WVALID_S  (WVALID_S),
    .WREADY_S  (WREADY_S),
    .BID_S     (BID_S),
    .BRESP_S   (BRESP_S),
    .BVALID_S  (BVALID_S),
    .BREADY_S  (BREADY_S),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_bweb  (mem_bweb)
  );

  // Stimulus helpers: each starts just after a rising edge and returns 1 ns after the next one.
  task automatic aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                    input logic [1:0] burst, output logic rdy);
    AWID_S = id; AWADDR_S = addr; AWLEN_S = len; AWSIZE_S = 3'b010; AWBURST_S = burst;
    AWVALID_S = 1'b1;
    @(negedge clk); rdy = AWREADY_S;
    @(posedge clk); #1;
    AWVALID_S = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] s, input logic l,
                      output logic we, output logic [13:0] a, output logic [3:0] b,
                      output logic [31:0] wd, output logic wr);
    WDATA_S = d; WSTRB_S = s; WLAST_S = l; WVALID_S = 1'b1;
    @(negedge clk); we = mem_we; a = mem_addr; b = mem_bweb; wd = mem_wdata; wr = WREADY_S;
    @(posedge clk); #1;
    WVALID_S = 1'b0; WLAST_S = 1'b0; WSTRB_S = 4'h0; WDATA_S = '0;
  endtask

  task automatic resp(output logic bv, output logic [7:0] bid, output logic [1:0] br,
                      output logic awr);
    @(negedge clk); bv = BVALID_S; bid = BID_S; br = BRESP_S; awr = AWREADY_S;
    BREADY_S = 1'b1;
    @(posedge clk); #1;
    BREADY_S = 1'b0;
  endtask

  task automatic test_reset();
    WVALID_S = 1'b1; BREADY_S = 1'b1;
    @(negedge clk);
    tests_run++; if ({AWREADY_S, WREADY_S, BVALID_S, mem_we, mem_bweb} !== 8'h00) begin
      tests_failed++; $display("FAIL reset_outputs: got aw=%b w=%b b=%b we=%b bweb=%h expected all 0",
                               AWREADY_S, WREADY_S, BVALID_S, mem_we, mem_bweb); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    tests_run++; if (AWREADY_S !== 1'b1) begin
      tests_failed++; $display("FAIL idle_awready: got %b expected 1", AWREADY_S); end
    tests_run++; if ({WREADY_S, mem_we, BVALID_S} !== 3'b000) begin
      tests_failed++; $display("FAIL idle_w_blocked: got wready=%b we=%b bvalid=%b expected 0 0 0",
                               WREADY_S, mem_we, BVALID_S); end
    @(posedge clk); #1; WVALID_S = 1'b0; BREADY_S = 1'b0;
  endtask

  task automatic test_single_beat();
    logic rdy, we, wr, bv, awr; logic [13:0] a; logic [3:0] b; logic [31:0] wd;
    logic [7:0] bid; logic [1:0] br;
    aw(8'h21, 32'h0000_0010, 4'd0, 2'b01, rdy);
    tests_run++; if (rdy !== 1'b1) begin
      tests_failed++; $display("FAIL single_awready: got %b expected 1", rdy); end
    beat(32'hDEAD_BEEF, 4'hF, 1'b1, we, a, b, wd, wr);
    tests_run++; if ({wr, we, a, b, wd} !== {1'b1, 1'b1, 14'd4, 4'hF, 32'hDEAD_BEEF}) begin
      tests_failed++; $display("FAIL single_write: got wr=%b we=%b addr=%h bweb=%h wdata=%h expected 1 1 0004 f deadbeef",
                               wr, we, a, b, wd); end
    resp(bv, bid, br, awr);
    tests_run++; if ({bv, bid, br, awr} !== {1'b1, 8'h21, 2'b00, 1'b0}) begin
      tests_failed++; $display("FAIL single_resp: got bvalid=%b bid=%h bresp=%b awready=%b expected 1 21 00 0",
                               bv, bid, br, awr); end
    @(negedge clk);
    tests_run++; if ({AWREADY_S, BVALID_S} !== 2'b10) begin
      tests_failed++; $display("FAIL single_back_idle: got awready=%b bvalid=%b expected 1 0", AWREADY_S, BVALID_S); end
    @(posedge clk); #1;
  endtask

  task automatic test_incr_strobe();
    logic rdy, we, wr, bv, awr; logic [13:0] a; logic [3:0] b, s; logic [31:0] wd;
    logic [7:0] bid; logic [1:0] br;
    aw(8'h35, 32'h0000_0100, 4'd3, 2'b01, rdy);
    for (int i = 0; i < 4; i++) begin
      s = (i == 2) ? 4'b0011 : 4'hF;
      beat(32'h1000_0000 + i, s, (i == 3), we, a, b, wd, wr);
      tests_run++; if ({we, a, b} !== {1'b1, 14'h40 + 14'(i), s}) begin
        tests_failed++; $display("FAIL incr_beat%0d: got we=%b addr=%h bweb=%b expected 1 %h %b",
                                 i, we, a, b, 14'h40 + 14'(i), s); end
    end
    resp(bv, bid, br, awr);
    tests_run++; if ({bv, bid, br} !== {1'b1, 8'h35, 2'b00}) begin
      tests_failed++; $display("FAIL incr_resp: got bvalid=%b bid=%h bresp=%b expected 1 35 00", bv, bid, br); end
  endtask

  task automatic test_fixed_gapped();
    logic rdy, we, wr, bv, awr; logic [13:0] a; logic [3:0] b; logic [31:0] wd;
    logic [7:0] bid; logic [1:0] br;
    aw(8'h4A, 32'h0000_0020, 4'd2, 2'b00, rdy);
    beat(32'hA0A0_A0A0, 4'hF, 1'b0, we, a, b, wd, wr);
    tests_run++; if ({we, a} !== {1'b1, 14'd8}) begin
      tests_failed++; $display("FAIL fixed_beat0: got we=%b addr=%h expected 1 0008", we, a); end
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      tests_run++; if ({mem_we, WREADY_S} !== 2'b01) begin
        tests_failed++; $display("FAIL fixed_gap%0d: got we=%b wready=%b expected 0 1", g, mem_we, WREADY_S); end
      @(posedge clk); #1;
    end
    for (int i = 1; i < 3; i++) begin
      beat(32'hB0B0_B0B0 + i, 4'hF, (i == 2), we, a, b, wd, wr);
      tests_run++; if ({we, a} !== {1'b1, 14'd8}) begin
        tests_failed++; $display("FAIL fixed_beat%0d: got we=%b addr=%h expected 1 0008", i, we, a); end
    end
    resp(bv, bid, br, awr);
    tests_run++; if ({bv, bid, br} !== {1'b1, 8'h4A, 2'b00}) begin
      tests_failed++; $display("FAIL fixed_resp: got bvalid=%b bid=%h bresp=%b expected 1 4a 00", bv, bid, br); end
  endtask

  task automatic test_out_of_range();
    logic rdy, we, wr, bv, awr; logic [13:0] a; logic [3:0] b; logic [31:0] wd;
    logic [7:0] bid; logic [1:0] br;
    aw(8'h5B, 32'h0001_0000, 4'd1, 2'b01, rdy);
    for (int i = 0; i < 2; i++) begin
      beat(32'h5555_0000 + i, 4'hF, (i == 1), we, a, b, wd, wr);
      tests_run++; if ({wr, we, b} !== {1'b1, 1'b0, 4'h0}) begin
        tests_failed++; $display("FAIL oor_beat%0d: got wready=%b we=%b bweb=%h expected 1 0 0", i, wr, we, b); end
    end
    resp(bv, bid, br, awr);
    tests_run++; if ({bv, bid, br} !== {1'b1, 8'h5B, 2'b10}) begin
      tests_failed++; $display("FAIL oor_resp: got bvalid=%b bid=%h bresp=%b expected 1 5b 10", bv, bid, br); end
  endtask

  task automatic test_wlast_early_hold();
    logic rdy, we, wr, bv, awr; logic [13:0] a; logic [3:0] b; logic [31:0] wd;
    logic [7:0] bid; logic [1:0] br;
    aw(8'h6C, 32'h0000_0040, 4'd1, 2'b01, rdy);
    for (int i = 0; i < 2; i++) begin
      beat(32'h6666_0000 + i, 4'hF, 1'b1, we, a, b, wd, wr);
      tests_run++; if ({we, a} !== {1'b1, 14'h10 + 14'(i)}) begin
        tests_failed++; $display("FAIL early_beat%0d: got we=%b addr=%h expected 1 %h", i, we, a, 14'h10 + 14'(i)); end
    end
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      tests_run++; if ({BVALID_S, BID_S, BRESP_S, AWREADY_S} !== {1'b1, 8'h6C, 2'b10, 1'b0}) begin
        tests_failed++; $display("FAIL hold%0d: got bvalid=%b bid=%h bresp=%b awready=%b expected 1 6c 10 0",
                                 h, BVALID_S, BID_S, BRESP_S, AWREADY_S); end
      @(posedge clk); #1;
    end
    resp(bv, bid, br, awr);
    tests_run++; if ({bv, bid, br} !== {1'b1, 8'h6C, 2'b10}) begin
      tests_failed++; $display("FAIL early_resp: got bvalid=%b bid=%h bresp=%b expected 1 6c 10", bv, bid, br); end
    @(negedge clk);
    tests_run++; if (AWREADY_S !== 1'b1) begin
      tests_failed++; $display("FAIL early_awready_after: got %b expected 1", AWREADY_S); end
    @(posedge clk); #1;
  endtask

  task automatic test_wlast_missing();
    logic rdy, we, wr, bv, awr; logic [13:0] a; logic [3:0] b; logic [31:0] wd;
    logic [7:0] bid; logic [1:0] br;
    aw(8'h92, 32'h0000_0080, 4'd1, 2'b01, rdy);
    for (int i = 0; i < 2; i++) begin
      beat(32'h9999_0000 + i, 4'hF, 1'b0, we, a, b, wd, wr);
      tests_run++; if ({we, a} !== {1'b1, 14'h20 + 14'(i)}) begin
        tests_failed++; $display("FAIL nolast_beat%0d: got we=%b addr=%h expected 1 %h", i, we, a, 14'h20 + 14'(i)); end
    end
    resp(bv, bid, br, awr);
    tests_run++; if ({bv, br} !== {1'b1, 2'b10}) begin
      tests_failed++; $display("FAIL nolast_resp: got bvalid=%b bresp=%b expected 1 10", bv, br); end
  endtask

  task automatic test_incr_overflow();
    logic rdy, we, wr, bv, awr; logic [13:0] a; logic [3:0] b; logic [31:0] wd;
    logic [7:0] bid; logic [1:0] br;
    aw(8'h7D, 32'h0000_FFFC, 4'd1, 2'b01, rdy);
    beat(32'h7777_0000, 4'hF, 1'b0, we, a, b, wd, wr);
    tests_run++; if ({we, a} !== {1'b1, 14'h3FFF}) begin
      tests_failed++; $display("FAIL ovf_beat0: got we=%b addr=%h expected 1 3fff", we, a); end
    beat(32'h7777_0001, 4'hF, 1'b1, we, a, b, wd, wr);
    tests_run++; if ({we, b} !== {1'b0, 4'h0}) begin
      tests_failed++; $display("FAIL ovf_beat1: got we=%b bweb=%h expected 0 0", we, b); end
    resp(bv, bid, br, awr);
    tests_run++; if ({bv, bid, br} !== {1'b1, 8'h7D, 2'b10}) begin
      tests_failed++; $display("FAIL ovf_resp: got bvalid=%b bid=%h bresp=%b expected 1 7d 10", bv, bid, br); end
  endtask

  task automatic test_wrap_burst();
    logic rdy, we, wr, bv, awr; logic [13:0] a; logic [3:0] b; logic [31:0] wd;
    logic [7:0] bid; logic [1:0] br;
    aw(8'hA3, 32'h0000_0000, 4'd0, 2'b10, rdy);
    beat(32'hAAAA_AAAA, 4'hF, 1'b1, we, a, b, wd, wr);
    tests_run++; if ({wr, we} !== 2'b10) begin
      tests_failed++; $display("FAIL wrap_beat: got wready=%b we=%b expected 1 0", wr, we); end
    resp(bv, bid, br, awr);
    tests_run++; if ({bv, bid, br} !== {1'b1, 8'hA3, 2'b10}) begin
      tests_failed++; $display("FAIL wrap_resp: got bvalid=%b bid=%h bresp=%b expected 1 a3 10", bv, bid, br); end
  endtask

  task automatic test_reset_mid_burst();
    logic rdy, we, wr; logic [13:0] a; logic [3:0] b; logic [31:0] wd;
    logic bv_seen;
    aw(8'h8E, 32'h0000_0200, 4'd3, 2'b01, rdy);
    for (int i = 0; i < 2; i++) begin
      beat(32'h8888_0000 + i, 4'hF, 1'b0, we, a, b, wd, wr);
      tests_run++; if ({we, a} !== {1'b1, 14'h80 + 14'(i)}) begin
        tests_failed++; $display("FAIL rstmid_beat%0d: got we=%b addr=%h expected 1 %h", i, we, a, 14'h80 + 14'(i)); end
    end
    WDATA_S = 32'h8888_0002; WSTRB_S = 4'hF; WVALID_S = 1'b1; rst = 1'b1;
    @(negedge clk);
    tests_run++; if ({mem_we, mem_bweb, AWREADY_S, WREADY_S} !== 7'b0) begin
      tests_failed++; $display("FAIL rstmid_cut: got we=%b bweb=%h awready=%b wready=%b expected 0 0 0 0",
                               mem_we, mem_bweb, AWREADY_S, WREADY_S); end
    @(posedge clk); #1;
    rst = 1'b0; WVALID_S = 1'b0; WSTRB_S = 4'h0; BREADY_S = 1'b1;
    @(negedge clk);
    tests_run++; if ({AWREADY_S, WREADY_S} !== 2'b10) begin
      tests_failed++; $display("FAIL rstmid_idle: got awready=%b wready=%b expected 1 0", AWREADY_S, WREADY_S); end
    bv_seen = BVALID_S;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); bv_seen = bv_seen | BVALID_S;
    end
    tests_run++; if (bv_seen !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_no_resp: got bvalid seen=%b expected 0", bv_seen); end
    @(posedge clk); #1; BREADY_S = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    AWID_S = '0; AWADDR_S = '0; AWLEN_S = '0; AWSIZE_S = 3'b010; AWBURST_S = 2'b01; AWVALID_S = 1'b0;
    WDATA_S = '0; WSTRB_S = '0; WLAST_S = 1'b0; WVALID_S = 1'b0; BREADY_S = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_beat();
    test_incr_strobe();
    test_fixed_gapped();
    test_out_of_range();
    test_wlast_early_hold();
    test_wlast_missing();
    test_incr_overflow();
    test_wrap_burst();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
